// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-side PC sequencer: FSM state encoding,
// default reset PC / increment, and the wrapping PC add helper.
package pc_seq_pkg;

    localparam int PC_W = 16;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // one dead cycle after reset release
        ST_REQ  = 2'd1,   // ready to issue a request at r_pc
        ST_WAIT = 2'd2,   // request outstanding, address held stable
        ST_HALT = 2'd3    // fetching stopped until reset
    } state_t;

    localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;
    localparam logic [PC_W-1:0] DEF_PC_INC   = 16'd1;

    // Sequential step; the sum is truncated to PC_W bits so FFFF+1 wraps to 0000.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                                input logic [PC_W-1:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC priority mux.
// Priority: jump > branch > buffered (pending) redirect > sequential increment.
// o_redirect_hit flags that the chosen PC is a redirect target, which tells
// the sequencer to discard any word fetched from the old path.
module next_pc_sel
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_pc_inc,
    input  logic            i_jmp,
    input  logic [PC_W-1:0] i_jmp_target,
    input  logic            i_br_taken,
    input  logic [PC_W-1:0] i_br_target,
    input  logic            i_pend_valid,
    input  logic [PC_W-1:0] i_pend_target,
    output logic [PC_W-1:0] o_next_pc,
    output logic            o_redirect_hit
);

    // Pick the highest-priority PC source; default is the sequential step
    always_comb begin
        o_next_pc      = pc_add(i_pc, i_pc_inc);
        o_redirect_hit = 1'b0;
        if (i_jmp) begin
            o_next_pc      = i_jmp_target;
            o_redirect_hit = 1'b1;
        end else if (i_br_taken) begin
            o_next_pc      = i_br_target;
            o_redirect_hit = 1'b1;
        end else if (i_pend_valid) begin
            o_next_pc      = i_pend_target;
            o_redirect_hit = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: owns the program counter, issues instruction
// memory requests, buffers one fetched instruction for decode, and handles
// branch/jump redirects (immediate or deferred until an outstanding fetch
// returns), decode stall and halt.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC,
    parameter logic [15:0] PC_INC   = DEF_PC_INC
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        jmp,
    input  logic [15:0] jmp_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_out,
    output logic        halted
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_pend_valid;
    logic [15:0] r_pend_target;
    logic        r_halt_seen;
    logic        r_instr_valid;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t      w_state_next;
    logic        w_req;
    logic        w_ack_fire;
    logic        w_active;
    logic        w_jmp;
    logic        w_br;
    logic        w_new_redir;
    logic        w_halt_any;
    logic        w_buf_free;
    logic [15:0] w_next_pc;
    logic        w_redirect_hit;

    // Redirects have no effect once halted; the buffered word still drains.
    assign w_active    = (r_state != ST_HALT);
    assign w_jmp       = jmp & w_active;
    assign w_br        = br_taken & w_active;
    assign w_new_redir = w_jmp | w_br;

    // A halt request seen this cycle counts immediately, not just next cycle.
    assign w_halt_any  = halt | r_halt_seen;

    // The buffer can take a new word if it is empty or being consumed now.
    assign w_buf_free  = ~r_instr_valid | ~stall;

    next_pc_sel u_next_pc_sel (
        .i_pc           (r_pc),
        .i_pc_inc       (PC_INC),
        .i_jmp          (w_jmp),
        .i_jmp_target   (jmp_target),
        .i_br_taken     (w_br),
        .i_br_target    (br_target),
        .i_pend_valid   (r_pend_valid),
        .i_pend_target  (r_pend_target),
        .o_next_pc      (w_next_pc),
        .o_redirect_hit (w_redirect_hit)
    );

    // FSM next state, memory request and fetch-completion decode
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_ack_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
            end
            ST_REQ: begin
                // No request is outstanding here, so halt stops fetching at once.
                if (w_halt_any) begin
                    w_state_next = ST_HALT;
                end else if (w_buf_free) begin
                    w_req = 1'b1;
                    if (imem_ack) begin
                        w_ack_fire   = 1'b1;
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_ack_fire   = 1'b1;
                    w_state_next = w_halt_any ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter and deferred-redirect register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 16'h0000;
        end else if (w_ack_fire) begin
            // Fetch returns: step sequentially or take the winning redirect.
            r_pc         <= w_next_pc;
            r_pend_valid <= 1'b0;
        end else if (w_new_redir) begin
            if (w_req) begin
                // A request is in flight at r_pc; keep the address stable and
                // apply the target when the ack arrives (later redirects win).
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_next_pc;
            end else begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Halt request latch; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halt_seen <= 1'b0;
        end else if (halt) begin
            r_halt_seen <= 1'b1;
        end
    end

    // One-entry instruction buffer toward decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_valid <= 1'b0;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
        end else if (w_ack_fire && !w_redirect_hit) begin
            r_instr_valid <= 1'b1;
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
        end else if (w_new_redir || w_ack_fire) begin
            // Redirect flushes; an ack reaching here carried a wrong-path word.
            r_instr_valid <= 1'b0;
        end else if (r_instr_valid && !stall) begin
            r_instr_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign halted      = (r_state == ST_HALT);

endmodule
